// File: rtl/bb_ioreg_turn_pkg.sv
// Shared definitions for the registered bidirectional I/O stage:
// FSM state encoding, tristate polarity and the turnaround counter width.
package bb_ioreg_turn_pkg;

    typedef enum logic [1:0] {
        S_RX    = 2'd0,
        S_TA_TX = 2'd1,
        S_TX    = 2'd2,
        S_TA_RX = 2'd3
    } state_t;

    localparam logic T_HIZ   = 1'b1;
    localparam logic T_DRIVE = 1'b0;

    localparam int CNT_W = 4;

    function automatic logic is_turnaround(input state_t s);
        return (s == S_TA_TX) || (s == S_TA_RX);
    endfunction

endpackage

// File: rtl/bb_ioreg_bit.sv
// One lane of the I/O stage: the I, T and receive flops for a single BB pad.
// The pad primitive itself sits outside, on the BB_I/BB_T/BB_O ports of the top.
module bb_ioreg_bit
    import bb_ioreg_turn_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic drive_next,
    input  logic txd,
    input  logic bb_o,
    output logic bb_i,
    output logic bb_t,
    output logic rxd
);

    // Pad controls follow the upcoming state; receive side samples the pad every enabled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bb_i <= 1'b0;
            bb_t <= T_HIZ;
            rxd  <= 1'b0;
        end else if (ce) begin
            bb_t <= drive_next ? T_DRIVE : T_HIZ;
            if (drive_next) begin
                bb_i <= txd;
            end
            rxd <= bb_o;
        end
    end

endmodule

// File: rtl/bb_ioreg_turn.sv
// Registered bidirectional bus stage with a counted, tristated turnaround
// window on every direction change so the pad is never driven while it is
// being handed over.
module bb_ioreg_turn #(
    parameter int W         = 8,
    parameter int TA_CYCLES = 1
) (
    input  logic         SCLK,
    input  logic         RSTN,
    input  logic         CE,
    input  logic         DIR_REQ,
    input  logic [W-1:0] TXD,
    output logic         DIR_ACK,
    output logic         BUSY,
    output logic [W-1:0] RXD,
    output logic         RXD_VALID,
    output logic [W-1:0] BB_I,
    output logic [W-1:0] BB_T,
    input  logic [W-1:0] BB_O
);

    import bb_ioreg_turn_pkg::*;

    // The counter is loaded with one less than the window length and the
    // state exits on the edge it is found at zero, giving TA_CYCLES edges.
    localparam int              TA_M1   = (TA_CYCLES > 0) ? TA_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TA_LOAD = CNT_W'(TA_M1);
    localparam bit              TA_ZERO = (TA_CYCLES == 0);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             drive_nxt;

    // Next-state and counter logic; a turnaround can't be abandoned before it expires.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_RX: begin
                if (DIR_REQ) begin
                    if (TA_ZERO) begin
                        state_nxt = S_TX;
                    end else begin
                        state_nxt = S_TA_TX;
                        cnt_nxt   = TA_LOAD;
                    end
                end
            end
            S_TA_TX: begin
                if (cnt == '0) begin
                    state_nxt = DIR_REQ ? S_TX : S_RX;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_TX: begin
                if (!DIR_REQ) begin
                    if (TA_ZERO) begin
                        state_nxt = S_RX;
                    end else begin
                        state_nxt = S_TA_RX;
                        cnt_nxt   = TA_LOAD;
                    end
                end
            end
            S_TA_RX: begin
                if (cnt == '0) begin
                    state_nxt = S_RX;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_RX;
                cnt_nxt   = '0;
            end
        endcase
        drive_nxt = (state_nxt == S_TX);
    end

    // State, counter and status flags; reset releases the bus with no turnaround.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= S_RX;
            cnt       <= '0;
            DIR_ACK   <= 1'b0;
            BUSY      <= 1'b0;
            RXD_VALID <= 1'b0;
        end else if (CE) begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            DIR_ACK   <= drive_nxt;
            BUSY      <= is_turnaround(state_nxt);
            RXD_VALID <= (state == S_RX);
        end
    end

    genvar b;
    generate
        for (b = 0; b < W; b++) begin : g_lane
            bb_ioreg_bit u_lane (
                .clk        (SCLK),
                .rst_n      (RSTN),
                .ce         (CE),
                .drive_next (drive_nxt),
                .txd        (TXD[b]),
                .bb_o       (BB_O[b]),
                .bb_i       (BB_I[b]),
                .bb_t       (BB_T[b]),
                .rxd        (RXD[b])
            );
        end
    endgenerate

endmodule

// File: tb/tb_bb_ioreg_turn.sv
// Bench for bb_ioreg_turn: four instances with turnaround lengths 0..3 share
// one stimulus stream; each has an external pad driver and a behavioural model.
module tb_bb_ioreg_turn;

    localparam int W = 8;
    localparam int N = 4;

    logic         SCLK = 1'b0;
    logic         RSTN = 1'b1;
    logic         CE = 1'b0;
    logic         DIR_REQ = 1'b0;
    logic [W-1:0] TXD = '0;
    logic [W-1:0] ext_drive = '0;

    logic [N-1:0][W-1:0] bb_i_w;
    logic [N-1:0][W-1:0] bb_t_w;
    logic [N-1:0][W-1:0] bb_o_w;
    logic [N-1:0][W-1:0] rxd_w;
    logic [N-1:0]        ack_w;
    logic [N-1:0]        busy_w;
    logic [N-1:0]        valid_w;

    int checks = 0;
    int failures = 0;
    bit compare_en = 1'b0;

    // Free-running clock, 10 time units per period.
    always #5 SCLK = ~SCLK;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            bb_ioreg_turn #(.W(W), .TA_CYCLES(g)) dut (
                .SCLK      (SCLK),
                .RSTN      (RSTN),
                .CE        (CE),
                .DIR_REQ   (DIR_REQ),
                .TXD       (TXD),
                .DIR_ACK   (ack_w[g]),
                .BUSY      (busy_w[g]),
                .RXD       (rxd_w[g]),
                .RXD_VALID (valid_w[g]),
                .BB_I      (bb_i_w[g]),
                .BB_T      (bb_t_w[g]),
                .BB_O      (bb_o_w[g])
            );
            assign bb_o_w[g] = (bb_i_w[g] & ~bb_t_w[g]) | (ext_drive & bb_t_w[g]);
        end
    endgenerate

    // Behavioural model: the bus is either driven, idle-receiving, or in a
    // turnaround with some number of enabled edges still to go.
    bit           m_drv   [N];
    int           m_left  [N];
    bit           m_to_tx [N];
    logic [W-1:0] m_i     [N];
    logic [W-1:0] m_rxd   [N];
    bit           m_valid [N];

    // Model update on each enabled clock edge, reset asynchronously.
    always @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int k = 0; k < N; k++) begin
                m_drv[k]   = 1'b0;
                m_left[k]  = 0;
                m_to_tx[k] = 1'b0;
                m_i[k]     = '0;
                m_rxd[k]   = '0;
                m_valid[k] = 1'b0;
            end
        end else if (CE) begin
            for (int k = 0; k < N; k++) begin : model_lane
                bit was_drv;
                int was_left;
                was_drv  = m_drv[k];
                was_left = m_left[k];
                m_rxd[k]   = was_drv ? m_i[k] : ext_drive;
                m_valid[k] = !was_drv && (was_left == 0);
                if (was_left > 0) begin
                    m_left[k] = was_left - 1;
                    if (m_left[k] == 0 && m_to_tx[k] && DIR_REQ) begin
                        m_drv[k] = 1'b1;
                    end
                end else if (!was_drv && DIR_REQ) begin
                    if (k == 0) begin
                        m_drv[k] = 1'b1;
                    end else begin
                        m_left[k]  = k;
                        m_to_tx[k] = 1'b1;
                    end
                end else if (was_drv && !DIR_REQ) begin
                    m_drv[k]   = 1'b0;
                    m_left[k]  = k;
                    m_to_tx[k] = 1'b0;
                end
                if (m_drv[k]) begin
                    m_i[k] = TXD;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ce, input logic req, input logic [W-1:0] txd,
                                 input logic [W-1:0] ext);
        CE        = ce;
        DIR_REQ   = req;
        TXD       = txd;
        ext_drive = ext;
    endtask

    task automatic tick();
        @(posedge SCLK);
        @(negedge SCLK);
    endtask

    // Compare every instance against the model away from the active edge.
    always @(negedge SCLK) begin
        if (compare_en) begin
            for (int k = 0; k < N; k++) begin
                checkOutput($sformatf("ta%0d_bb_t", k), bb_t_w[k], m_drv[k] ? 8'h00 : 8'hFF);
                checkOutput($sformatf("ta%0d_bb_i", k), bb_i_w[k], m_i[k]);
                checkOutput($sformatf("ta%0d_dir_ack", k), ack_w[k], m_drv[k]);
                checkOutput($sformatf("ta%0d_busy", k), busy_w[k], m_left[k] > 0);
                checkOutput($sformatf("ta%0d_rxd", k), rxd_w[k], m_rxd[k]);
                checkOutput($sformatf("ta%0d_rxd_valid", k), valid_w[k], m_valid[k]);
            end
        end
    end

    // Directed scenarios with hand-computed expectations, then a random soak.
    initial begin
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        #3 RSTN = 1'b0;
        #1 compare_en = 1'b1;
        @(negedge SCLK);
        checkOutput("reset_bb_t", bb_t_w[1], 8'hFF);
        checkOutput("reset_rxd_valid", valid_w[1], 1'b0);
        RSTN = 1'b1;

        // Receive, then acquire the bus
        applyStimulus(1'b1, 1'b0, 8'h00, 8'hA5);
        tick();
        checkOutput("rx_capture", rxd_w[1], 8'hA5);
        checkOutput("rx_valid", valid_w[1], 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h00, 8'hA5);
        tick();
        checkOutput("acq_busy", busy_w[1], 1'b1);
        checkOutput("acq_t_hiz", bb_t_w[1], 8'hFF);
        checkOutput("ta0_direct_t", bb_t_w[0], 8'h00);
        checkOutput("ta0_direct_ack", ack_w[0], 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h3C, 8'hA5);
        tick();
        checkOutput("acq_t_drive", bb_t_w[1], 8'h00);
        checkOutput("acq_ack", ack_w[1], 1'b1);
        checkOutput("acq_busy_done", busy_w[1], 1'b0);
        checkOutput("drive_3c", bb_i_w[1], 8'h3C);
        checkOutput("pad_3c", bb_o_w[1], 8'h3C);
        applyStimulus(1'b1, 1'b1, 8'hC3, 8'hA5);
        tick();
        checkOutput("drive_c3", bb_i_w[1], 8'hC3);
        checkOutput("pad_c3", bb_o_w[1], 8'hC3);
        checkOutput("ta2_drive", bb_t_w[2], 8'h00);
        tick();
        checkOutput("ta3_drive", bb_t_w[3], 8'h00);

        // Release the bus
        applyStimulus(1'b1, 1'b0, 8'hC3, 8'hA5);
        tick();
        checkOutput("rel_t_hiz", bb_t_w[2], 8'hFF);
        checkOutput("rel_ack", ack_w[2], 1'b0);
        checkOutput("rel_busy1", busy_w[2], 1'b1);
        checkOutput("rel_valid1", valid_w[2], 1'b0);
        tick();
        checkOutput("rel_busy2", busy_w[2], 1'b1);
        checkOutput("rel_valid2", valid_w[2], 1'b0);
        tick();
        checkOutput("rel_busy3", busy_w[2], 1'b0);
        checkOutput("rel_valid3", valid_w[2], 1'b0);
        tick();
        checkOutput("rel_valid4", valid_w[2], 1'b1);

        // Short request that is withdrawn during the turnaround
        applyStimulus(1'b1, 1'b1, 8'h55, 8'h0F);
        tick();
        checkOutput("abort_busy1", busy_w[3], 1'b1);
        checkOutput("abort_t1", bb_t_w[3], 8'hFF);
        applyStimulus(1'b1, 1'b0, 8'h55, 8'h0F);
        tick();
        checkOutput("abort_busy2", busy_w[3], 1'b1);
        checkOutput("abort_t2", bb_t_w[3], 8'hFF);
        tick();
        checkOutput("abort_busy3", busy_w[3], 1'b1);
        checkOutput("abort_t3", bb_t_w[3], 8'hFF);
        tick();
        checkOutput("abort_busy4", busy_w[3], 1'b0);
        checkOutput("abort_t4", bb_t_w[3], 8'hFF);
        checkOutput("abort_ack4", ack_w[3], 1'b0);
        tick();
        tick();

        // Clock enable held low in the middle of a turnaround
        applyStimulus(1'b1, 1'b1, 8'h99, 8'h0F);
        tick();
        checkOutput("ce_enter_busy", busy_w[3], 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h99, 8'h0F);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("ce_hold_busy", busy_w[3], 1'b1);
            checkOutput("ce_hold_t", bb_t_w[3], 8'hFF);
        end
        applyStimulus(1'b1, 1'b1, 8'h99, 8'h0F);
        tick();
        checkOutput("ce_resume1", busy_w[3], 1'b1);
        tick();
        checkOutput("ce_resume2", bb_t_w[3], 8'hFF);
        tick();
        checkOutput("ce_resume3_t", bb_t_w[3], 8'h00);
        checkOutput("ce_resume3_ack", ack_w[3], 1'b1);

        // Asynchronous reset while driving
        #2 RSTN = 1'b0;
        #1;
        checkOutput("async_t", bb_t_w[3], 8'hFF);
        checkOutput("async_ack", ack_w[3], 1'b0);
        checkOutput("async_rxd", rxd_w[3], 8'h00);
        checkOutput("async_valid", valid_w[3], 1'b0);
        @(negedge SCLK);
        RSTN = 1'b1;

        // Random soak with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            logic req;
            req = DIR_REQ;
            if ($urandom_range(0, 5) == 0) begin
                req = ~req;
            end
            applyStimulus($urandom_range(0, 7) != 0, req, W'($urandom), W'($urandom));
            if (i % 1000 == 999) begin
                #2 RSTN = 1'b0;
                @(negedge SCLK);
                RSTN = 1'b1;
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
